// File: rtl/ysyx_2022040010_div_seq_pkg.sv
// Shared definitions for the iterative divider sequencer.
// Contents:
//   - XLEN and CNT_W widths
//   - RV64M DIV* funct3 decode constants
//   - divider FSM state type
//   - a 32->64 sign-extension helper
package ysyx_2022040010_div_seq_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  localparam logic [2:0] DIV_F3_DIV  = 3'b100;
  localparam logic [2:0] DIV_F3_DIVU = 3'b101;
  localparam logic [2:0] DIV_F3_REM  = 3'b110;
  localparam logic [2:0] DIV_F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_2022040010_add.sv
// Shared XLEN-bit adder.
// Ports:
//   in_a, in_b  : operands
//   in_c        : carry-in
//   alu_32      : 1 = sign-extend sum[31:0] to XLEN
//   sum         : result
//   cout        : carry out of bit XLEN-1
module ysyx_2022040010_add
  import ysyx_2022040010_div_seq_pkg::*;
(
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_c,
  input  logic            alu_32,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  logic [XLEN:0] full;

  assign full = {1'b0, in_a} + {1'b0, in_b} + {{XLEN{1'b0}}, in_c};
  assign sum  = alu_32 ? sext32(full[31:0]) : full[XLEN-1:0];
  assign cout = full[XLEN];

endmodule

// File: rtl/ysyx_2022040010_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W forms.
// It produces one quotient bit per cycle. A single shared adder serves
// as the CALC subtractor and as the FIX negator.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   div_valid/div_ready           : request handshake (ready only in IDLE)
//   div_signed, div_word, div_rem : operation flags
//   dividend, divisor             : operands, sampled at accept
//   flush                         : abort, returns to IDLE
//   out_valid/out_ready           : result handshake
//   result                        : quotient or remainder
module ysyx_2022040010_div_seq
  import ysyx_2022040010_div_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            div_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e state, state_nxt;

  logic [XLEN-1:0]  rem_r, quo_r, dsr_r;
  logic [CNT_W-1:0] cnt;
  logic             sgn_r, word_r, rsel_r, qneg_r, rneg_r;
  logic             accept;

  // PREP-stage operand conditioning (quo_r/dsr_r hold the raw operands here)
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val;
  logic            sa, sb, b_zero, ovf, special;

  // CALC / FIX datapath
  logic [XLEN-1:0] shifted, add_a, add_b, add_sum, fix_sel, fix_val, fix_out;
  logic            add_cout, acc_bit, fix_neg, in_fix;

  assign div_ready = (state == DIV_IDLE);
  assign out_valid = (state == DIV_DONE);
  assign accept    = div_valid & div_ready & ~flush;

  assign a_ext   = word_r ? (sgn_r ? sext32(quo_r[31:0]) : {32'b0, quo_r[31:0]}) : quo_r;
  assign b_ext   = word_r ? (sgn_r ? sext32(dsr_r[31:0]) : {32'b0, dsr_r[31:0]}) : dsr_r;
  assign sa      = sgn_r & a_ext[XLEN-1];
  assign sb      = sgn_r & b_ext[XLEN-1];
  assign mag_a   = sa ? -a_ext : a_ext;
  assign mag_b   = sb ? -b_ext : b_ext;
  assign min_val = word_r ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign b_zero  = (b_ext == '0);
  assign ovf     = sgn_r & (a_ext == min_val) & (b_ext == '1);
  assign special = b_zero | ovf;

  // The bit shifted out of R acts as the 65th bit of the partial remainder.
  // When it is set, the subtraction is always non-negative.
  assign shifted = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
  assign acc_bit = add_cout | rem_r[XLEN-1];

  assign in_fix  = (state == DIV_FIX);
  assign fix_sel = rsel_r ? rem_r : quo_r;
  assign fix_neg = rsel_r ? rneg_r : qneg_r;
  assign add_a   = in_fix ? '0 : shifted;
  assign add_b   = in_fix ? ~fix_sel : ~dsr_r;
  assign fix_val = fix_neg ? add_sum : fix_sel;
  assign fix_out = word_r ? sext32(fix_val[31:0]) : fix_val;

  ysyx_2022040010_add u_add (
    .in_a   (add_a),
    .in_b   (add_b),
    .in_c   (1'b1),
    .alu_32 (1'b0),
    .sum    (add_sum),
    .cout   (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_PREP;
      DIV_PREP: state_nxt = special ? DIV_FIX : DIV_CALC;
      DIV_CALC: if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX:  state_nxt = DIV_DONE;
      DIV_DONE: if (out_ready) state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (flush) state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dsr_r  <= '0;
      cnt    <= '0;
      sgn_r  <= 1'b0;
      word_r <= 1'b0;
      rsel_r <= 1'b0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (accept) begin
          quo_r  <= dividend;
          dsr_r  <= divisor;
          sgn_r  <= div_signed;
          word_r <= div_word;
          rsel_r <= div_rem;
        end
        DIV_PREP: begin
          qneg_r <= 1'b0;
          rneg_r <= 1'b0;
          if (b_zero) begin
            quo_r <= '1;
            rem_r <= a_ext;
          end else if (ovf) begin
            quo_r <= a_ext;
            rem_r <= '0;
          end else begin
            // Word dividends are left-aligned so that the quotient ends up in [31:0]
            quo_r  <= word_r ? {mag_a[31:0], 32'b0} : mag_a;
            rem_r  <= '0;
            dsr_r  <= word_r ? {32'b0, mag_b[31:0]} : mag_b;
            qneg_r <= sa ^ sb;
            rneg_r <= sa;
            cnt    <= word_r ? CNT_W'(XLEN / 2 - 1) : CNT_W'(XLEN - 1);
          end
        end
        DIV_CALC: begin
          rem_r <= acc_bit ? add_sum : shifted;
          quo_r <= {quo_r[XLEN-2:0], acc_bit};
          cnt   <= cnt - 1'b1;
        end
        DIV_FIX: if (!flush) result <= fix_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_div_seq.sv
module tb_ysyx_2022040010_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid, div_ready, div_signed, div_word, div_rem;
  logic [63:0] dividend, divisor, result;
  logic        flush, out_valid, out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference-side record of the transaction in flight
  logic        pending = 1'b0;
  logic [63:0] m_exp   = '0;
  int          m_lat   = 0;
  int          m_acc   = 0;
  logic        prev_ov = 1'b0;

  always #5 clk = ~clk;

  ysyx_2022040010_div_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_word   (div_word),
    .div_rem    (div_rem),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%016h required=0x%016h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics, computed with plain arithmetic
  function automatic logic [63:0] model(input logic s, input logic w, input logic r,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, v32;
    logic [63:0] q64, r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      v32 = r ? r32 : q32;
      return {{32{v32[31]}}, v32};
    end
    if (b == 64'd0) begin
      q64 = '1; r64 = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = '0;
    end else if (s) begin
      q64 = $signed(a) / $signed(b);
      r64 = $signed(a) % $signed(b);
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return r ? r64 : q64;
  endfunction

  function automatic int model_lat(input logic s, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic sp;
    if (w) sp = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   sp = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    return sp ? 2 : (w ? 34 : 66);
  endfunction

  // Records each accepted request and its expected outcome
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) pending <= 1'b0;
    else if (flush) pending <= 1'b0;
    else if (div_valid && div_ready) begin
      pending <= 1'b1;
      m_exp   <= model(div_signed, div_word, div_rem, dividend, divisor);
      m_lat   <= model_lat(div_signed, div_word, dividend, divisor);
      m_acc   <= cyc;
    end else if (out_valid && out_ready) pending <= 1'b0;
  end

  // Compares the DUT against the model on every cycle that out_valid is high
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!pending) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        chk("model_result", result, m_exp);
        if (!prev_ov) chk("model_latency", 64'(cyc - m_acc - 1), 64'(m_lat));
      end
      chk("ready_while_valid", 64'(div_ready), 64'd0);
    end
    prev_ov = out_valid;
  end

  task automatic start_op(input logic s, input logic w, input logic r,
                          input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    while (!div_ready && n < 200) begin @(posedge clk); #1; n++; end
    div_signed = s; div_word = w; div_rem = r;
    dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
  endtask

  task automatic run_op(input string name, input logic s, input logic w, input logic r,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int n;
    out_ready = (hold == 0);
    start_op(s, w, r, a, b);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      chk({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({name, "_result"}, result, exp);
    chk({name, "_latency"}, 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_held_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_held_result"}, result, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_consumed_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_consumed_ready"}, 64'(div_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0; div_rem = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_ready", 64'(div_ready), 64'd1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu_100_7",   0, 0, 0, 64'd100, 64'd7, 64'd14, 66, 0);
    run_op("remu_100_7",   0, 0, 1, 64'd100, 64'd7, 64'd2,  66, 0);
    run_op("div_m7_2",     1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("rem_m7_2",     1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("div_7_m2",     1, 0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("rem_7_m2",     1, 0, 1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 0);
    run_op("divu_max_3",   0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 66, 0);
    run_op("divu_by0",     0, 0, 0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("rem_by0",      1, 0, 1, 64'd123, 64'd0, 64'd123, 2, 0);
    run_op("div_ovf",      1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 0);
    run_op("rem_ovf",      1, 0, 1, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
    run_op("divw_ovf",     1, 1, 0, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2, 0);
    run_op("divuw_hi",     0, 1, 0, 64'hDEAD_BEEF_FFFF_FFFE, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
    run_op("remw_m7_2",    1, 1, 1, 64'hDEAD_BEEF_FFFF_FFF9, 64'hDEAD_BEEF_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    run_op("remuw_hold",   0, 1, 1, 64'h0000_0000_8000_0005, 64'd2, 64'd1, 34, 5);

    // Flush partway through CALC: the operation is dropped with no result
    out_ready = 1'b1;
    start_op(0, 0, 0, 64'd100, 64'd7);
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(div_ready), 64'd1);
    chk("flush_result_kept", result, 64'd1);
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush_no_result", 64'(seen), 64'd0);

    // A request that coincides with flush in IDLE is not accepted
    div_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", 64'(div_ready), 64'd1);

    // Asynchronous reset mid-CALC
    start_op(0, 0, 0, 64'd1000, 64'd3);
    repeat (20) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(div_ready), 64'd1);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_reset",  0, 0, 0, 64'd1000, 64'd3, 64'd333, 66, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
